// File: rtl/radio_monitor_pkg.sv
// Shared types and constants for the radio monitor: channel packing, FSM states and the
// valid-pulse range check.
package radio_monitor_pkg;

    localparam int unsigned CH_W       = 10;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned VAL_MAX    = 1000;
    localparam int unsigned FS_CTR_DEF = 500;

    typedef logic [CH_W-1:0] ch_val_t;

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArmed    = 2'd1,
        StFailsafe = 2'd2
    } state_e;

    // 0 means no pulse was captured; anything above VAL_MAX is a corrupt measurement.
    function automatic logic val_in_range(ch_val_t v);
        return (v != '0) && (v <= ch_val_t'(VAL_MAX));
    endfunction

endpackage

// File: rtl/radio_watchdog.sv
// Per-channel pulse watchdog: synchronises one raw radio pin, detects rising edges and flags
// the channel as lost once no edge has been seen for TIMEOUT ticks.
module radio_watchdog #(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic tmr_1Mhz,
    input  logic rst,
    input  logic sig,
    output logic lost
);

    localparam logic [15:0] TimeoutV = 16'(TIMEOUT);

    logic        sync1_q, sync2_q, prev_q;
    logic        rise;
    logic [15:0] cnt_q, cnt_d;

    assign rise = sync2_q && !prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != TimeoutV) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter starts saturated so the channel reads lost until its first edge.
    always_ff @(posedge tmr_1Mhz) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= TimeoutV;
        end else begin
            sync1_q <= sig;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign lost = (cnt_q == TimeoutV);

endmodule

// File: rtl/radio_monitor.sv
// Radio health monitor: per-channel health, failsafe substitution and the arm/disarm/failsafe
// state machine that gates throttle before commands reach the controller.
module radio_monitor
    import radio_monitor_pkg::*;
#(
    parameter int unsigned     TIMEOUT   = 25000,
    parameter int unsigned     ARM_HOLD  = 1000000,
    parameter int unsigned     THR_CH    = 0,
    parameter int unsigned     YAW_CH    = 3,
    parameter int unsigned     THR_LOW   = 50,
    parameter int unsigned     YAW_HI    = 950,
    parameter int unsigned     YAW_LO    = 50,
    parameter int unsigned     FS_CTR    = FS_CTR_DEF,
    parameter logic [NUM_CH-1:0] CRIT_MASK = 8'h0F
) (
    input  logic                   tmr_1Mhz,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      radio_sig,
    input  logic [NUM_CH*CH_W-1:0] radio_val,
    output logic [NUM_CH*CH_W-1:0] cmd_val,
    output logic [NUM_CH-1:0]      ch_ok,
    output logic                   armed,
    output logic                   failsafe,
    output logic [1:0]             state
);

    localparam ch_val_t     ThrLowV  = ch_val_t'(THR_LOW);
    localparam ch_val_t     YawHiV   = ch_val_t'(YAW_HI);
    localparam ch_val_t     YawLoV   = ch_val_t'(YAW_LO);
    localparam ch_val_t     FsCtrV   = ch_val_t'(FS_CTR);
    localparam logic [19:0] HoldMax  = 20'(ARM_HOLD);
    localparam logic [19:0] HoldLast = 20'(ARM_HOLD - 1);

    ch_val_t [NUM_CH-1:0] val_in, val_q, cmd_q, cmd_d;
    logic    [NUM_CH-1:0] lost, ok_d;
    state_e               state_q, state_d;
    logic    [19:0]       hold_q, hold_d;
    logic                 crit_ok, thr_low, arm_gest, disarm_gest, gest;
    ch_val_t              thr, yaw;

    assign val_in = radio_val;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_wd
        radio_watchdog #(
            .TIMEOUT (TIMEOUT)
        ) u_wd (
            .tmr_1Mhz (tmr_1Mhz),
            .rst      (rst),
            .sig      (radio_sig[n]),
            .lost     (lost[n])
        );
    end

    always_comb begin
        ok_d = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            ok_d[n] = !lost[n] && val_in_range(val_in[n]);
        end
    end

    // Gestures use the registered health but the live stick values.
    assign thr         = val_in[THR_CH];
    assign yaw         = val_in[YAW_CH];
    assign crit_ok     = &(ch_ok | ~CRIT_MASK);
    assign thr_low     = thr < ThrLowV;
    assign arm_gest    = crit_ok && thr_low && (yaw > YawHiV);
    assign disarm_gest = thr_low && (yaw < YawLoV);

    always_comb begin
        state_d = state_q;
        gest    = 1'b0;
        case (state_q)
            StDisarmed: begin
                gest = arm_gest;
                if (arm_gest && hold_q == HoldLast) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                gest = disarm_gest;
                if (!crit_ok) begin
                    state_d = StFailsafe;
                end else if (disarm_gest && hold_q == HoldLast) begin
                    state_d = StDisarmed;
                end
            end
            StFailsafe: begin
                if (crit_ok && thr_low) begin
                    state_d = StDisarmed;
                end
            end
            default: state_d = StDisarmed;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (!gest || state_d != state_q) begin
            hold_d = '0;
        end else if (hold_q != HoldMax) begin
            hold_d = hold_q + 20'd1;
        end
    end

    // Commands pair ch_ok with the same sample it judged, so a bad value never leaks through.
    always_comb begin
        cmd_d = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (ch_ok[n]) begin
                cmd_d[n] = val_q[n];
            end else begin
                cmd_d[n] = (n == THR_CH) ? '0 : FsCtrV;
            end
        end
        if (state_d != StArmed) begin
            cmd_d[THR_CH] = '0;
        end
    end

    always_ff @(posedge tmr_1Mhz) begin
        if (rst) begin
            state_q  <= StDisarmed;
            hold_q   <= '0;
            ch_ok    <= '0;
            val_q    <= '0;
            armed    <= 1'b0;
            failsafe <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cmd_q[n] <= (n == THR_CH) ? '0 : FsCtrV;
            end
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ch_ok    <= ok_d;
            val_q    <= val_in;
            armed    <= (state_d == StArmed);
            failsafe <= (state_d == StFailsafe);
            cmd_q    <= cmd_d;
        end
    end

    assign cmd_val = cmd_q;
    assign state   = state_q;

endmodule

// File: tb/tb_radio_monitor.sv
// Directed bench for radio_monitor: table of steady-state vectors while armed plus hand-written
// sequences for arming, channel loss, failsafe recovery, broken gestures and reset.
module tb_radio_monitor;
    import radio_monitor_pkg::*;

    localparam int unsigned TO = 100;
    localparam int unsigned AH = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  radio_sig;
    logic [79:0] radio_val;
    logic [79:0] cmd_val;
    logic [7:0]  ch_ok;
    logic        armed, failsafe;
    logic [1:0]  state;

    int          cyc = 0;
    logic [7:0]  pulse_mask = 8'hFF;
    int          last_rise[8];
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [9:0] thr;
        logic [9:0] yaw;
        logic [9:0] ch5;
        logic [7:0] exp_ok;
        logic [1:0] exp_state;
        logic [9:0] exp_cmd0;
        logic [9:0] exp_cmd5;
    } vec_t;

    vec_t vecs[6];

    radio_monitor #(
        .TIMEOUT  (TO),
        .ARM_HOLD (AH)
    ) dut (
        .tmr_1Mhz  (clk),
        .rst       (rst),
        .radio_sig (radio_sig),
        .radio_val (radio_val),
        .cmd_val   (cmd_val),
        .ch_ok     (ch_ok),
        .armed     (armed),
        .failsafe  (failsafe),
        .state     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pins rise every 50 cycles for 10 cycles on every channel enabled in pulse_mask.
    initial begin
        radio_sig = '0;
        for (int i = 0; i < 8; i++) last_rise[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc % 50 == 10) begin
                radio_sig = pulse_mask;
                for (int i = 0; i < 8; i++) if (pulse_mask[i]) last_rise[i] = cyc;
            end else if (cyc % 50 == 20) begin
                radio_sig = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_ch(input int n, input logic [9:0] v);
        radio_val[n*10 +: 10] = v;
    endtask

    function automatic logic [9:0] cmd_ch(input int n);
        return cmd_val[n*10 +: 10];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        logic [79:0] exp_cmd;
        for (int n = 0; n < 8; n++) exp_cmd[n*10 +: 10] = (n == 0) ? 10'd0 : 10'd500;
        check({tag, "_ch_ok"}, 32'(ch_ok), 32'h00);
        check({tag, "_armed"}, 32'(armed), 32'd0);
        check({tag, "_failsafe"}, 32'(failsafe), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        n_vec++;
        if (cmd_val !== exp_cmd) begin
            n_err++;
            $display("FAIL %s_cmd_val: got 0x%0h expected 0x%0h", tag, cmd_val, exp_cmd);
        end
    endtask

    task automatic wait_all_ok(input int max_cyc);
        int k = 0;
        while (ch_ok !== 8'hFF && k < max_cyc) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_phase30();
        while (cyc % 50 != 30) tick();
    endtask

    initial begin
        int k;
        logic seen_armed;

        //            thr      yaw      ch5       ok     st  cmd0     cmd5
        vecs[0] = '{10'd10,  10'd500, 10'd500,  8'hFF, 2'd1, 10'd10,  10'd500};
        vecs[1] = '{10'd30,  10'd500, 10'd1001 - 10'd0, 8'hDF, 2'd1, 10'd30, 10'd500};
        vecs[2] = '{10'd30,  10'd500, 10'd0,    8'hDF, 2'd1, 10'd30,  10'd500};
        vecs[3] = '{10'd40,  10'd500, 10'd1000, 8'hFF, 2'd1, 10'd40,  10'd1000};
        vecs[4] = '{10'd700, 10'd500, 10'd1,    8'hFF, 2'd1, 10'd700, 10'd1};
        vecs[5] = '{10'd10,  10'd49,  10'd500,  8'hFF, 2'd1, 10'd10,  10'd500};

        rst = 1'b1;
        for (int n = 0; n < 8; n++) set_ch(n, 10'd500);
        set_ch(0, 10'd10);
        ticks(3);
        check_reset("reset");

        // Bring-up: every channel healthy, throttle still gated while disarmed.
        rst = 1'b0;
        wait_all_ok(200);
        check("ch_ok_up", 32'(ch_ok), 32'hFF);
        tick();
        check("disarmed_after_up", 32'(state), 32'd0);
        check("thr_gated_disarmed", 32'(cmd_ch(0)), 32'd0);
        check("yaw_pass_disarmed", 32'(cmd_ch(3)), 32'd500);

        // Arm gesture: armed appears on exactly the AH-th sampled cycle.
        set_ch(3, 10'd1000);
        ticks(AH - 1);
        check("arm_not_early", 32'(armed), 32'd0);
        tick();
        check("arm_on_time", 32'(armed), 32'd1);
        check("state_armed", 32'(state), 32'd1);
        check("thr_pass_armed", 32'(cmd_ch(0)), 32'd10);
        set_ch(3, 10'd500);

        for (int i = 0; i < 6; i++) begin
            set_ch(0, vecs[i].thr);
            set_ch(3, vecs[i].yaw);
            set_ch(5, vecs[i].ch5);
            ticks(2);
            check($sformatf("vec%0d_ch_ok", i), 32'(ch_ok), 32'(vecs[i].exp_ok));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_cmd0", i), 32'(cmd_ch(0)), 32'(vecs[i].exp_cmd0));
            check($sformatf("vec%0d_cmd5", i), 32'(cmd_ch(5)), 32'(vecs[i].exp_cmd5));
        end
        set_ch(0, 10'd10);
        set_ch(3, 10'd500);
        set_ch(5, 10'd500);

        // ch2 loss: pin rise at t -> counter 0 at t+3 -> saturates at t+103 -> ch_ok low at t+104.
        wait_phase30();
        pulse_mask[2] = 1'b0;
        k = 0;
        while (ch_ok[2] !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        check("ch2_loss_latency", 32'(cyc - last_rise[2]), 32'd104);
        check("armed_on_loss_cycle", 32'(state), 32'd1);
        tick();
        check("fs_state", 32'(state), 32'd2);
        check("fs_flag", 32'(failsafe), 32'd1);
        check("fs_armed_low", 32'(armed), 32'd0);
        check("fs_cmd2", 32'(cmd_ch(2)), 32'd500);
        check("fs_cmd0", 32'(cmd_ch(0)), 32'd0);

        // Recovery needs low throttle as well as healthy critical channels.
        set_ch(0, 10'd600);
        wait_phase30();
        pulse_mask[2] = 1'b1;
        ticks(40);
        check("ch2_back", 32'(ch_ok), 32'hFF);
        check("fs_hold_thr_high", 32'(state), 32'd2);
        check("fs_thr_forced", 32'(cmd_ch(0)), 32'd0);
        set_ch(0, 10'd10);
        tick();
        check("fs_to_disarmed", 32'(state), 32'd0);
        check("fs_not_armed", 32'(armed), 32'd0);

        // Broken gesture: 19 + release + 19 must never arm.
        seen_armed = 1'b0;
        set_ch(3, 10'd1000);
        for (int i = 0; i < AH - 1; i++) begin tick(); seen_armed |= armed; end
        set_ch(3, 10'd500);
        tick();
        seen_armed |= armed;
        set_ch(3, 10'd1000);
        for (int i = 0; i < AH - 1; i++) begin tick(); seen_armed |= armed; end
        set_ch(3, 10'd500);
        tick();
        seen_armed |= armed;
        check("broken_gesture", 32'(seen_armed), 32'd0);

        // Full arm then disarm with yaw = 10.
        set_ch(3, 10'd1000);
        ticks(AH);
        check("rearm", 32'(armed), 32'd1);
        set_ch(3, 10'd10);
        ticks(AH - 1);
        check("disarm_not_early", 32'(state), 32'd1);
        tick();
        check("disarm_on_time", 32'(state), 32'd0);

        // Reset while armed and mid-disarm-gesture.
        set_ch(3, 10'd1000);
        ticks(AH);
        check("arm_again", 32'(armed), 32'd1);
        set_ch(3, 10'd10);
        ticks(5);
        rst = 1'b1;
        tick();
        check_reset("reset_armed");
        rst = 1'b0;
        tick();
        check("ok_low_after_reset", 32'(ch_ok), 32'h00);
        wait_all_ok(200);
        check("ok_back_after_reset", 32'(ch_ok), 32'hFF);
        check("disarmed_after_reset", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
